// File: rtl/spmv_pkg.sv
// Shared types and FP16 constants for the CSR SpMV engine.
//   FP16 encodings, exponent bias, engine state enum and the A/B pair payload.
package spmv_pkg;

  localparam int unsigned FP16_W   = 16;
  localparam int unsigned EXP_BIAS = 15;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_PINF = 16'h7C00;
  localparam logic [FP16_W-1:0] FP16_NINF = 16'hFC00;
  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One streamed nonzero: matrix value and its gathered vector element.
  typedef struct packed {
    logic [FP16_W-1:0] a;
    logic [FP16_W-1:0] b;
  } pair_t;

endpackage

// File: rtl/spmv_csr_engine_if.sv
// Control, pair stream and result bus of the CSR SpMV engine.
//   master: drives start / row pointers / pair stream, observes status and sums.
//   slave : the engine side.
interface spmv_csr_engine_if #(
  parameter int unsigned N_ROWS = 16,
  parameter int unsigned PTR_W  = 8
);
  logic                        i_start;
  logic [(N_ROWS+1)*PTR_W-1:0] i_row_ptr;
  logic                        i_valid;
  logic [15:0]                 i_read_data_A;
  logic [15:0]                 i_read_data_B;
  logic                        o_ready;
  logic                        o_busy;
  logic                        o_done;
  logic [N_ROWS*16-1:0]        o_register;

  modport master (
    output i_start, i_row_ptr, i_valid, i_read_data_A, i_read_data_B,
    input  o_ready, o_busy, o_done, o_register
  );

  modport slave (
    input  i_start, i_row_ptr, i_valid, i_read_data_A, i_read_data_B,
    output o_ready, o_busy, o_done, o_register
  );
endinterface

// File: rtl/spmv_csr_engine_fp16_mac.sv
// Combinational FP16 multiply-accumulate: o_sum_c = trunc_add(i_acc, trunc_mul(i_a, i_b)).
//   Subnormals flush to zero, truncating rounding, saturating overflow, canonical qNaN.
//   i_acc, i_a, i_b : FP16 operands     o_sum_c : FP16 result
module fp16_mac
  import spmv_pkg::*;
(
  input  logic [15:0] i_acc,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum_c
);

  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [21:0] prod;
    logic [9:0]  m;
    int          e;
    logic [15:0] r;
    s = a[15] ^ b[15];
    if ((a[14:10] == 5'h1F && a[9:0] != 10'd0) || (b[14:10] == 5'h1F && b[9:0] != 10'd0)) begin
      r = FP16_QNAN;
    end else if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) begin
      // Inf times a (flushed) zero is invalid.
      r = (a[14:10] == 5'd0 || b[14:10] == 5'd0) ? FP16_QNAN : {s, FP16_PINF[14:0]};
    end else if (a[14:10] == 5'd0 || b[14:10] == 5'd0) begin
      r = {s, 15'd0};
    end else begin
      prod = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
      e    = int'(a[14:10]) + int'(b[14:10]) - int'(EXP_BIAS);
      if (prod[21]) begin
        m = 10'(prod >> 11);
        e = e + 1;
      end else begin
        m = 10'(prod >> 10);
      end
      if (e >= 31)     r = {s, FP16_PINF[14:0]};
      else if (e <= 0) r = {s, 15'd0};
      else             r = {s, 5'(e), m};
    end
    return r;
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] big;
    logic [15:0] sml;
    logic [24:0] big_m;
    logic [24:0] sml_m;
    logic [24:0] sml_sh;
    logic [4:0]  d;
    logic        sticky;
    logic [25:0] sum;
    logic [9:0]  m;
    int          p;
    int          e;
    logic [15:0] r;
    if ((a[14:10] == 5'h1F && a[9:0] != 10'd0) || (b[14:10] == 5'h1F && b[9:0] != 10'd0)) begin
      r = FP16_QNAN;
    end else if (a[14:10] == 5'h1F && b[14:10] == 5'h1F) begin
      r = (a[15] != b[15]) ? FP16_QNAN : a;
    end else if (a[14:10] == 5'h1F) begin
      r = a;
    end else if (b[14:10] == 5'h1F) begin
      r = b;
    end else if (a[14:10] == 5'd0 && b[14:10] == 5'd0) begin
      r = FP16_ZERO;
    end else if (a[14:10] == 5'd0) begin
      r = b;
    end else if (b[14:10] == 5'd0) begin
      r = a;
    end else begin
      if (a[14:0] >= b[14:0]) begin
        big = a;
        sml = b;
      end else begin
        big = b;
        sml = a;
      end
      d      = big[14:10] - sml[14:10];
      big_m  = {1'b1, big[9:0], 14'd0};
      sml_m  = {1'b1, sml[9:0], 14'd0};
      sml_sh = sml_m >> d;
      // Bits shifted out only matter for subtraction, where they pull the
      // exact result just below the truncated difference.
      sticky = ((sml_sh << d) != sml_m);
      if (big[15] != sml[15]) sum = {1'b0, big_m} - {1'b0, sml_sh} - 26'(sticky);
      else                    sum = {1'b0, big_m} + {1'b0, sml_sh};
      if (sum == 26'd0) begin
        r = FP16_ZERO;
      end else begin
        p = 0;
        for (int i = 0; i < 26; i++) begin
          if (sum[i]) p = i;
        end
        m = (p >= 10) ? 10'(sum >> (p - 10)) : 10'(sum << (10 - p));
        e = int'(big[14:10]) + p - 24;
        if (e >= 31)     r = {big[15], FP16_PINF[14:0]};
        else if (e <= 0) r = {big[15], 15'd0};
        else             r = {big[15], 5'(e), m};
      end
    end
    return r;
  endfunction

  always_comb begin
    o_sum_c = fp16_add(i_acc, fp16_mul(i_a, i_b));
  end

endmodule

// File: rtl/spmv_csr_engine.sv
// CSR sparse-matrix x dense-vector engine: streams (A, B) pairs and accumulates A*B into
// the row selected by the latched row pointers.
//   i_clk, i_rstn : clock, async active-low reset
//   bus (slave)   : start/row pointers, valid/ready pair stream, busy/done status, row sums
module spmv_csr_engine
  import spmv_pkg::*;
#(
  parameter int unsigned N_ROWS = 16,
  parameter int unsigned PTR_W  = 8
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  spmv_csr_engine_if.slave    bus
);

  localparam int unsigned ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  state_t                 r_state;
  state_t                 w_state_d;
  logic                   r_ready, r_busy, r_done;
  logic                   w_ready_d, w_busy_d, w_done_d;
  logic [PTR_W-1:0]       r_ptr    [N_ROWS+1];
  logic [PTR_W-1:0]       w_ptr_in [N_ROWS+1];
  logic [PTR_W-1:0]       r_k;
  logic [PTR_W-1:0]       r_end;
  logic [PTR_W-1:0]       w_k_next;
  logic [15:0]            r_acc    [N_ROWS];
  logic [ROW_W-1:0]       w_row;
  logic                   w_start_acc;
  logic                   w_accept;
  logic [15:0]            w_mac_sum;
  pair_t                  w_pair;

  // Unpack the flat pointer vector.
  always_comb begin
    for (int r = 0; r <= int'(N_ROWS); r++) begin
      w_ptr_in[r] = bus.i_row_ptr[r*PTR_W +: PTR_W];
    end
  end

  assign w_start_acc = (r_state == ST_IDLE) && bus.i_start;
  assign w_accept    = bus.i_valid && r_ready;
  assign w_k_next    = r_k + PTR_W'(1);
  assign w_pair      = {bus.i_read_data_A, bus.i_read_data_B};

  // Row owning element k; later matches win so the largest qualifying row is chosen.
  always_comb begin
    w_row = '0;
    for (int r = 0; r < int'(N_ROWS); r++) begin
      if (r_ptr[r] <= r_k && r_k < r_ptr[r+1]) w_row = ROW_W'(r);
    end
  end

  fp16_mac u_mac (
    .i_acc   (r_acc[w_row]),
    .i_a     (w_pair.a),
    .i_b     (w_pair.b),
    .o_sum_c (w_mac_sum)
  );

  // Next state and registered status outputs.
  always_comb begin
    w_state_d = r_state;
    w_ready_d = 1'b0;
    w_busy_d  = 1'b0;
    w_done_d  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_state_d = (w_ptr_in[N_ROWS] <= w_ptr_in[0]) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept && (w_k_next == r_end)) w_state_d = ST_DONE;
      end
      ST_DONE: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
    w_ready_d = (w_state_d == ST_RUN);
    w_busy_d  = (w_state_d != ST_IDLE);
    w_done_d  = (w_state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ready <= w_ready_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  // Pointer latch, element counter and accumulator array.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int r = 0; r <= int'(N_ROWS); r++) r_ptr[r] <= '0;
      for (int r = 0; r < int'(N_ROWS); r++)  r_acc[r] <= FP16_ZERO;
      r_k   <= '0;
      r_end <= '0;
    end else if (w_start_acc) begin
      for (int r = 0; r <= int'(N_ROWS); r++) r_ptr[r] <= w_ptr_in[r];
      for (int r = 0; r < int'(N_ROWS); r++)  r_acc[r] <= FP16_ZERO;
      r_k   <= w_ptr_in[0];
      r_end <= w_ptr_in[N_ROWS];
    end else if (w_accept) begin
      r_acc[w_row] <= w_mac_sum;
      r_k          <= w_k_next;
    end
  end

  always_comb begin
    for (int r = 0; r < int'(N_ROWS); r++) begin
      bus.o_register[r*16 +: 16] = r_acc[r];
    end
  end

  assign bus.o_ready = r_ready;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;

endmodule

// File: tb/tb_spmv_csr_engine.sv
// Self-checking bench for spmv_csr_engine: scoreboard of expected row sums per pair.
module tb_spmv_csr_engine;
  import spmv_pkg::*;

  localparam int unsigned N_ROWS = 16;
  localparam int unsigned PTR_W  = 8;

  typedef struct {
    int unsigned row;
    logic [15:0] val;
    int          k;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  spmv_csr_engine_if #(.N_ROWS(N_ROWS), .PTR_W(PTR_W)) bus ();

  spmv_csr_engine #(.N_ROWS(N_ROWS), .PTR_W(PTR_W)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ptr     [N_ROWS+1];
  real         racc    [N_ROWS];
  logic [15:0] exp_reg [N_ROWS];
  int          k_drv;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Encode a non-negative real that is exactly representable (truncates otherwise).
  function automatic logic [15:0] to_fp16(input real v);
    real m;
    int  e;
    int  frac;
    if (v == 0.0) return 16'h0000;
    m = v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    if (e + 15 >= 31) return 16'h7C00;
    if (e + 15 <= 0)  return 16'h0000;
    frac = $rtoi((m - 1.0) * 1024.0);
    return {1'b0, 5'(e + 15), 10'(frac)};
  endfunction

  function automatic int row_of(input int k);
    int row = 0;
    for (int r = 0; r < int'(N_ROWS); r++) begin
      if (ptr[r] <= k && k < ptr[r+1]) row = r;
    end
    return row;
  endfunction

  function automatic logic [(N_ROWS+1)*PTR_W-1:0] pack_ptr();
    logic [(N_ROWS+1)*PTR_W-1:0] v = '0;
    for (int r = 0; r <= int'(N_ROWS); r++) v[r*PTR_W +: PTR_W] = PTR_W'(ptr[r]);
    return v;
  endfunction

  function automatic logic [N_ROWS*16-1:0] pack_exp();
    logic [N_ROWS*16-1:0] v = '0;
    for (int r = 0; r < int'(N_ROWS); r++) v[r*16 +: 16] = exp_reg[r];
    return v;
  endfunction

  function automatic void set_ptr_s1();
    int p[17] = '{0, 0, 1, 2, 2, 3, 4, 4, 4, 7, 7, 7, 7, 9, 9, 9, 10};
    for (int r = 0; r <= int'(N_ROWS); r++) ptr[r] = p[r];
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic do_start(input bit zero_nnz);
    bus.i_row_ptr = pack_ptr();
    bus.i_start   = 1'b1;
    @(negedge clk);
    bus.i_start   = 1'b0;
    for (int r = 0; r < int'(N_ROWS); r++) begin
      racc[r]    = 0.0;
      exp_reg[r] = 16'h0000;
    end
    k_drv = ptr[0];
    check_val("start_clears_reg", 256'(bus.o_register), 256'(0));
    if (zero_nnz) begin
      check_val("znnz_done", 256'(bus.o_done), 256'(1));
      check_val("znnz_ready", 256'(bus.o_ready), 256'(0));
      check_val("znnz_busy", 256'(bus.o_busy), 256'(1));
      @(negedge clk);
      check_val("znnz_done_drop", 256'(bus.o_done), 256'(0));
      check_val("znnz_ready_idle", 256'(bus.o_ready), 256'(0));
    end else begin
      check_val("start_busy", 256'(bus.o_busy), 256'(1));
      check_val("start_ready", 256'(bus.o_ready), 256'(1));
      check_val("start_done", 256'(bus.o_done), 256'(0));
    end
  endtask

  // Push the expected row value, present the pair, pop and compare once accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input bit use_model,
                      input real av, input real bv, input logic [15:0] fixed_val, input int gap);
    exp_t e;
    exp_t got;
    bit   taken = 1'b0;
    int   budget = 20;
    e.row = row_of(k_drv);
    e.k   = k_drv;
    if (use_model) begin
      racc[e.row] = racc[e.row] + av * bv;
      e.val = to_fp16(racc[e.row]);
    end else begin
      e.val = fixed_val;
    end
    exp_reg[e.row] = e.val;
    sb.push_back(e);
    k_drv++;
    bus.i_valid       = 1'b1;
    bus.i_read_data_A = a;
    bus.i_read_data_B = b;
    while (!taken && budget > 0) begin
      taken = bus.o_ready;
      @(negedge clk);
      budget--;
    end
    got = sb.pop_front();
    if (!taken) check_val("accept_timeout", 256'(0), 256'(1));
    else check_val($sformatf("pair_k%0d_row%0d", got.k, got.row),
                   256'(bus.o_register[got.row*16 +: 16]), 256'(got.val));
    bus.i_valid       = 1'b0;
    bus.i_read_data_A = 16'($urandom);
    bus.i_read_data_B = 16'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_finish(input string tag);
    check_val({tag, "_done"}, 256'(bus.o_done), 256'(1));
    check_val({tag, "_busy"}, 256'(bus.o_busy), 256'(1));
    check_val({tag, "_ready"}, 256'(bus.o_ready), 256'(0));
    check_val({tag, "_reg"}, 256'(bus.o_register), 256'(pack_exp()));
    @(negedge clk);
    check_val({tag, "_done_drop"}, 256'(bus.o_done), 256'(0));
    check_val({tag, "_idle"}, 256'(bus.o_busy), 256'(0));
    check_val({tag, "_reg_hold"}, 256'(bus.o_register), 256'(pack_exp()));
  endtask

  // First test-plan matrix; optional 3x7 second pair and 1,0,0 valid gaps.
  task automatic run_s1(input string tag, input bit alt, input bit gaps);
    set_ptr_s1();
    do_start(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (alt && i == 1) send(16'h4200, 16'h4700, 1'b1, 3.0, 7.0, 16'h0, 0);
      else send(16'h4C00, 16'h4000, 1'b1, 16.0, 2.0, 16'h0, (gaps && i < 9) ? 2 : 0);
      if (i < 9) check_val({tag, "_no_early_done"}, 256'(bus.o_done), 256'(0));
    end
    check_finish(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start       = 1'b0;
    bus.i_row_ptr     = '0;
    bus.i_valid       = 1'b0;
    bus.i_read_data_A = 16'h0;
    bus.i_read_data_B = 16'h0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check_val("rst_ready", 256'(bus.o_ready), 256'(0));
    check_val("rst_busy", 256'(bus.o_busy), 256'(0));
    check_val("rst_done", 256'(bus.o_done), 256'(0));
    check_val("rst_reg", 256'(bus.o_register), 256'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    run_s1("s1", 1'b0, 1'b0);
    check_val("s1_row8_const", 256'(bus.o_register[8*16 +: 16]), 256'(16'h5600));
    run_s1("s2", 1'b1, 1'b0);
    check_val("s2_row2_const", 256'(bus.o_register[2*16 +: 16]), 256'(16'h4D40));
    run_s1("gap", 1'b0, 1'b1);

    // Zero-nnz matrix.
    for (int r = 0; r <= int'(N_ROWS); r++) ptr[r] = 5;
    bus.i_valid = 1'b1;
    do_start(1'b1);
    bus.i_valid = 1'b0;
    check_val("znnz_reg", 256'(bus.o_register), 256'(0));

    // Reset in the middle of a run.
    set_ptr_s1();
    do_start(1'b0);
    for (int i = 0; i < 4; i++) send(16'h4C00, 16'h4000, 1'b1, 16.0, 2.0, 16'h0, 0);
    #2 rstn = 1'b0;
    #1;
    check_val("mid_rst_ready", 256'(bus.o_ready), 256'(0));
    check_val("mid_rst_busy", 256'(bus.o_busy), 256'(0));
    check_val("mid_rst_reg", 256'(bus.o_register), 256'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_s1("after_rst", 1'b0, 1'b0);

    // FP16 edge pairs in rows 0..2, with a start pulse mid-run that must be ignored.
    ptr[0] = 0; ptr[1] = 1; ptr[2] = 2;
    for (int r = 3; r <= int'(N_ROWS); r++) ptr[r] = 3;
    do_start(1'b0);
    send(16'h7BFF, 16'h4000, 1'b0, 0.0, 0.0, 16'h7C00, 0);
    bus.i_row_ptr = '0;
    bus.i_start   = 1'b1;
    @(negedge clk);
    bus.i_start   = 1'b0;
    check_val("ign_start_busy", 256'(bus.o_busy), 256'(1));
    check_val("ign_start_ready", 256'(bus.o_ready), 256'(1));
    check_val("ign_start_row0", 256'(bus.o_register[15:0]), 256'(16'h7C00));
    send(16'h7C00, 16'h0000, 1'b0, 0.0, 0.0, 16'h7E00, 0);
    send(16'h0001, 16'h4000, 1'b0, 0.0, 0.0, 16'h0000, 0);
    check_finish("edge");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
